// File: rtl/pipe_stage_skid_pkg.sv
// Shared definitions for the elastic MIPS pipeline-stage registers.
// Other pipeline registers import this for the state type and default widths.
package pipe_pkg;

   // Stage occupancy state; the encoding equals the number of held entries.
   typedef enum logic [1:0] {
      StEmpty = 2'd0,
      StOne   = 2'd1,
      StTwo   = 2'd2
   } pipe_state_e;

   // sll $0,$0,0
   localparam logic [31:0] MIPS_NOP = 32'h0000_0000;

   localparam int unsigned DEFAULT_INSTR_W = 32;
   localparam int unsigned DEFAULT_ADDR_W  = 32;

endpackage

// File: rtl/pipe_stage_skid.sv
// Elastic pipeline-stage register with a 2-entry skid buffer.
// The main entry drives the outputs directly; the skid entry catches the beat accepted while
// downstream stalls, so in_ready depends only on local state and never on out_ready.
// Optional feature macro: PIPE_STAGE_BUBBLE_EN -- when defined, flush leaves a NOP bubble that
// keeps the incoming PC instead of emptying the stage.
module pipe_stage_skid
   import pipe_pkg::*;
#(
   parameter int unsigned          INSTR_W   = DEFAULT_INSTR_W,
   parameter int unsigned          ADDR_W    = DEFAULT_ADDR_W,
   parameter logic [INSTR_W-1:0]   NOP_INSTR = INSTR_W'(MIPS_NOP)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [INSTR_W-1:0] in_instr,
   input  logic [ADDR_W-1:0]  in_addr,
   input  logic               flush,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [INSTR_W-1:0] out_instr,
   output logic [ADDR_W-1:0]  out_addr,
   output logic [1:0]         occupancy
);

   pipe_state_e        state_q, state_d;
   logic               in_ready_q, in_ready_d;
   logic [INSTR_W-1:0] main_instr_q, main_instr_d;
   logic [ADDR_W-1:0]  main_addr_q, main_addr_d;
   logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;
   logic [ADDR_W-1:0]  skid_addr_q, skid_addr_d;
   logic               accept, drain;

   assign out_valid = (state_q != StEmpty);
   assign in_ready  = in_ready_q;
   assign out_instr = main_instr_q;
   assign out_addr  = main_addr_q;
   assign occupancy = state_q;

   assign accept = in_valid & in_ready_q;
   assign drain  = out_valid & out_ready;

   // Next-state and entry updates; flush overrides every handshake in its cycle.
   always_comb begin
      state_d      = state_q;
      main_instr_d = main_instr_q;
      main_addr_d  = main_addr_q;
      skid_instr_d = skid_instr_q;
      skid_addr_d  = skid_addr_q;
      if (flush) begin
`ifdef PIPE_STAGE_BUBBLE_EN
         state_d      = StOne;
         main_instr_d = NOP_INSTR;
         main_addr_d  = in_addr;
`else
         state_d      = StEmpty;
         main_instr_d = '0;
         main_addr_d  = '0;
`endif
         skid_instr_d = '0;
         skid_addr_d  = '0;
      end else begin
         unique case (state_q)
            StEmpty: begin
               if (accept) begin
                  state_d      = StOne;
                  main_instr_d = in_instr;
                  main_addr_d  = in_addr;
               end
            end
            StOne: begin
               if (accept && drain) begin
                  main_instr_d = in_instr;
                  main_addr_d  = in_addr;
               end else if (accept) begin
                  // Downstream stalled: park the new beat behind the one on display.
                  state_d      = StTwo;
                  skid_instr_d = in_instr;
                  skid_addr_d  = in_addr;
               end else if (drain) begin
                  state_d = StEmpty;
               end
            end
            StTwo: begin
               if (drain) begin
                  state_d      = StOne;
                  main_instr_d = skid_instr_q;
                  main_addr_d  = skid_addr_q;
               end
            end
            default: state_d = StEmpty;
         endcase
      end
   end

   // Ready is registered from the next state so it never depends on out_ready.
   always_comb begin
      in_ready_d = (state_d != StTwo);
   end

   // State and entry registers; reset drops anything held.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= StEmpty;
         in_ready_q   <= 1'b0;
         main_instr_q <= '0;
         main_addr_q  <= '0;
         skid_instr_q <= '0;
         skid_addr_q  <= '0;
      end else begin
         state_q      <= state_d;
         in_ready_q   <= in_ready_d;
         main_instr_q <= main_instr_d;
         main_addr_q  <= main_addr_d;
         skid_instr_q <= skid_instr_d;
         skid_addr_q  <= skid_addr_d;
      end
   end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: directed scenarios followed by random valid/ready/flush traffic,
// all compared against a queue-based model of the stage.
module tb_pipe_stage_skid;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;
   logic [31:0] in_addr;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [31:0] out_addr;
   logic [1:0]  occupancy;

   int checks   = 0;
   int failures = 0;

   // Model: beats held in arrival order, the payload last shown, and the ready flag.
   logic [63:0] mq[$];
   logic [63:0] m_last;
   logic        m_ready;

   pipe_stage_skid dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_instr  (in_instr),
      .in_addr   (in_addr),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_instr (out_instr),
      .out_addr  (out_addr),
      .occupancy (occupancy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      logic [63:0] exp_pl;
      exp_pl = (mq.size() != 0) ? mq[0] : m_last;
      chk({tag, ".occupancy"}, 64'(occupancy), 64'(mq.size()));
      chk({tag, ".out_valid"}, 64'(out_valid), 64'(mq.size() != 0));
      chk({tag, ".in_ready"}, 64'(in_ready), 64'(m_ready));
      chk({tag, ".payload"}, {out_instr, out_addr}, exp_pl);
   endtask

   task automatic model_reset();
      mq.delete();
      m_last  = 64'd0;
      m_ready = 1'b0;
   endtask

   // Drive one cycle of inputs, advance the model over the edge, then compare.
   task automatic cycle(input logic v, input logic [31:0] i, input logic [31:0] a,
                        input logic f, input logic r, input string tag);
      logic acc, drn;
      in_valid  = v;
      in_instr  = i;
      in_addr   = a;
      flush     = f;
      out_ready = r;
      acc = v & m_ready;
      drn = (mq.size() != 0) & r;
      @(posedge clk);
      if (f) begin
         mq.delete();
         m_last = 64'd0;
`ifdef PIPE_STAGE_BUBBLE_EN
         mq.push_back({32'h0000_0000, a});
`endif
      end else begin
         if (drn) void'(mq.pop_front());
         if (acc) mq.push_back({i, a});
      end
      if (mq.size() != 0) m_last = mq[0];
      m_ready = (mq.size() < 2);
      #1;
      check_all(tag);
   endtask

   initial begin
      rst = 1'b1;
      in_valid = 1'b0; in_instr = '0; in_addr = '0; flush = 1'b0; out_ready = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all("reset");
      rst = 1'b0;
      cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, "post_reset");

      // Back-to-back streaming with downstream always ready.
      for (int k = 0; k < 4; k++)
         cycle(1'b1, 32'h2001_0005 + k, 32'h0040_0000 + 4 * k, 1'b0, 1'b1, "stream");
      cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, "stream_tail");

      // Backpressure fills the skid entry, then drains in order.
      cycle(1'b1, 32'hAAAA_0001, 32'h0040_0100, 1'b0, 1'b0, "skid_a");
      cycle(1'b1, 32'hBBBB_0002, 32'h0040_0104, 1'b0, 1'b0, "skid_b");
      cycle(1'b1, 32'hCCCC_0003, 32'h0040_0108, 1'b0, 1'b0, "skid_hold");
      chk("skid_full_occ", 64'(occupancy), 64'd2);
      cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, "skid_drain_a");
      cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, "skid_drain_b");

      // Flush while full, with a beat offered at the same time.
      cycle(1'b1, 32'h1111_0001, 32'h0040_0200, 1'b0, 1'b0, "fl_a");
      cycle(1'b1, 32'h1111_0002, 32'h0040_0204, 1'b0, 1'b0, "fl_b");
      cycle(1'b1, 32'hC0C0_C0C0, 32'h0040_0010, 1'b1, 1'b1, "flush_two");
`ifdef PIPE_STAGE_BUBBLE_EN
      chk("bubble_instr", 64'(out_instr), 64'h0000_0000);
      chk("bubble_addr", 64'(out_addr), 64'h0040_0010);
      chk("bubble_valid", 64'(out_valid), 64'd1);
`else
      chk("flush_instr_zero", 64'(out_instr), 64'd0);
      chk("flush_addr_zero", 64'(out_addr), 64'd0);
      chk("flush_valid", 64'(out_valid), 64'd0);
`endif
      cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, "after_flush");

      // Flush in ONE with an accepted beat: that beat must be dropped.
      cycle(1'b1, 32'h2222_0001, 32'h0040_0300, 1'b0, 1'b0, "fl1_a");
      cycle(1'b1, 32'h2222_0002, 32'h0040_0304, 1'b1, 1'b0, "flush_one");
      cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, "after_flush_one");

      // Asynchronous reset in the middle of a cycle while full.
      cycle(1'b1, 32'h3333_0001, 32'h0040_0400, 1'b0, 1'b0, "rs_a");
      cycle(1'b1, 32'h3333_0002, 32'h0040_0404, 1'b0, 1'b0, "rs_b");
      in_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      model_reset();
      check_all("async_reset");
      @(posedge clk);
      #1;
      check_all("reset_held");
      rst = 1'b0;
      cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, "release");

      // Random traffic against the model.
      for (int n = 0; n < 10000; n++) begin
         cycle(1'($urandom_range(0, 1)), $urandom, $urandom, ($urandom_range(0, 31) == 0),
               1'($urandom_range(0, 2) != 0), "rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
